// File: rtl/fighter_pkg.sv
// rtl/fighter_pkg.sv - shared player action codes and attack decode for the fighter core
package fighter_pkg;

   localparam logic [2:0] IDLE    = 3'b000;
   localparam logic [2:0] MOVE    = 3'b001;
   localparam logic [2:0] JUMP    = 3'b010;
   localparam logic [2:0] BLOCK   = 3'b011;
   localparam logic [2:0] ATTACK1 = 3'b100;
   localparam logic [2:0] ATTACK2 = 3'b101;
   localparam logic [2:0] HIT     = 3'b111;

   function automatic logic is_attack(input logic [2:0] action);
      return (action == ATTACK1) || (action == ATTACK2);
   endfunction

endpackage

// File: rtl/hit_channel.sv
// rtl/hit_channel.sv - one attack direction: hitbox select, overlap test, hit-once latch, hit/block decode
module hit_channel
   import fighter_pkg::*;
#(
   parameter int                           POS_WIDTH   = 10,
   parameter int                           NUM_ATK     = 2,
   parameter int                           IDX_W       = 1,
   parameter int                           DMG_WIDTH   = 4,
   parameter logic [NUM_ATK*DMG_WIDTH-1:0] ATK_DAMAGE  = {4'd5, 4'd3},
   parameter int                           CHIP_DAMAGE = 1
) (
   input  logic                           clk,
   input  logic                           rst_n,
   input  logic                           frame_tick,
   input  logic [2:0]                     atk_action,
   input  logic [IDX_W-1:0]               atk_idx,
   input  logic [NUM_ATK*POS_WIDTH-1:0]   hitbox_left,
   input  logic [NUM_ATK*POS_WIDTH-1:0]   hitbox_right,
   input  logic                           atk_stunned,
   input  logic [2:0]                     def_action,
   input  logic [POS_WIDTH-1:0]           hurt_left,
   input  logic [POS_WIDTH-1:0]           hurt_right,
   output logic                           hit,
   output logic                           block,
   output logic [DMG_WIDTH-1:0]           dmg
);

   localparam logic [DMG_WIDTH-1:0] CHIP_VAL = CHIP_DAMAGE[DMG_WIDTH-1:0];

   logic [POS_WIDTH-1:0] sel_left;
   logic [POS_WIDTH-1:0] sel_right;
   logic [DMG_WIDTH-1:0] sel_dmg;
   logic                 idx_valid;
   logic                 attacking;
   logic                 stale;
   logic                 overlap;
   logic                 connect;
   logic                 connected;
   logic [IDX_W-1:0]     latched_idx;

   // Out-of-range indices select nothing and are treated as not attacking.
   always_comb begin
      sel_left  = '0;
      sel_right = '0;
      sel_dmg   = '0;
      idx_valid = 1'b0;
      for (int k = 0; k < NUM_ATK; k++) begin
         if (int'(atk_idx) == k) begin
            sel_left  = hitbox_left[k*POS_WIDTH +: POS_WIDTH];
            sel_right = hitbox_right[k*POS_WIDTH +: POS_WIDTH];
            sel_dmg   = ATK_DAMAGE[k*DMG_WIDTH +: DMG_WIDTH];
            idx_valid = 1'b1;
         end
      end
   end

   assign attacking = is_attack(atk_action) && idx_valid;
   // A stale latch no longer blocks, so a switched attack may connect this very tick.
   assign stale     = !attacking || (atk_idx != latched_idx);
   assign overlap   = (sel_right >= hurt_left) && (sel_left <= hurt_right);
   assign connect   = frame_tick && attacking && !atk_stunned && overlap && (!connected || stale);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         connected   <= 1'b0;
         latched_idx <= '0;
      end else if (frame_tick) begin
         if (connect) begin
            connected   <= 1'b1;
            latched_idx <= atk_idx;
         end else if (stale) begin
            connected   <= 1'b0;
         end
      end
   end

   assign block = connect && (def_action == BLOCK);
   assign hit   = connect && (def_action != BLOCK);
   assign dmg   = block ? CHIP_VAL : (hit ? sel_dmg : '0);

endmodule

// File: rtl/combat_resolver.sv
// rtl/combat_resolver.sv - two-player hit resolver: both hit channels, stun counters and registered pulses
module combat_resolver #(
   parameter int                           POS_WIDTH   = 10,
   parameter int                           NUM_ATK     = 2,
   parameter int                           DMG_WIDTH   = 4,
   parameter logic [NUM_ATK*DMG_WIDTH-1:0] ATK_DAMAGE  = {4'd5, 4'd3},
   parameter int                           CHIP_DAMAGE = 1,
   parameter int                           STUN_WIDTH  = 6,
   parameter int                           HITSTUN     = 20,
   parameter int                           BLOCKSTUN   = 8,
   localparam int                          IDX_W       = (NUM_ATK > 1) ? $clog2(NUM_ATK) : 1
) (
   input  logic                         clk,
   input  logic                         rst_n,
   input  logic                         frame_tick,
   input  logic [2:0]                   p1_action,
   input  logic [2:0]                   p2_action,
   input  logic [IDX_W-1:0]             p1_atk_idx,
   input  logic [IDX_W-1:0]             p2_atk_idx,
   input  logic [NUM_ATK*POS_WIDTH-1:0] p1_hitbox_left,
   input  logic [NUM_ATK*POS_WIDTH-1:0] p1_hitbox_right,
   input  logic [NUM_ATK*POS_WIDTH-1:0] p2_hitbox_left,
   input  logic [NUM_ATK*POS_WIDTH-1:0] p2_hitbox_right,
   input  logic [POS_WIDTH-1:0]         p1_hurtbox_left,
   input  logic [POS_WIDTH-1:0]         p1_hurtbox_right,
   input  logic [POS_WIDTH-1:0]         p2_hurtbox_left,
   input  logic [POS_WIDTH-1:0]         p2_hurtbox_right,
   output logic                         hit_p1_to_p2,
   output logic                         hit_p2_to_p1,
   output logic                         block_p1_to_p2,
   output logic                         block_p2_to_p1,
   output logic [DMG_WIDTH-1:0]         p1_dmg,
   output logic [DMG_WIDTH-1:0]         p2_dmg,
   output logic                         p1_stunned,
   output logic                         p2_stunned
);

   localparam logic [STUN_WIDTH-1:0] HIT_LOAD = HITSTUN[STUN_WIDTH-1:0];
   localparam logic [STUN_WIDTH-1:0] BLK_LOAD = BLOCKSTUN[STUN_WIDTH-1:0];
   localparam logic [STUN_WIDTH-1:0] STUN_ONE = 1;

   logic                  c12_hit, c12_block, c21_hit, c21_block;
   logic [DMG_WIDTH-1:0]  c12_dmg, c21_dmg;
   logic [STUN_WIDTH-1:0] p1_stun_cnt, p2_stun_cnt;

   // Both channels see the pre-tick stun flags, which is what lets a trade land both ways.
   assign p1_stunned = (p1_stun_cnt != '0);
   assign p2_stunned = (p2_stun_cnt != '0);

   hit_channel #(
      .POS_WIDTH(POS_WIDTH), .NUM_ATK(NUM_ATK), .IDX_W(IDX_W), .DMG_WIDTH(DMG_WIDTH),
      .ATK_DAMAGE(ATK_DAMAGE), .CHIP_DAMAGE(CHIP_DAMAGE)
   ) u_p1_to_p2 (
      .clk(clk), .rst_n(rst_n), .frame_tick(frame_tick),
      .atk_action(p1_action), .atk_idx(p1_atk_idx),
      .hitbox_left(p1_hitbox_left), .hitbox_right(p1_hitbox_right),
      .atk_stunned(p1_stunned), .def_action(p2_action),
      .hurt_left(p2_hurtbox_left), .hurt_right(p2_hurtbox_right),
      .hit(c12_hit), .block(c12_block), .dmg(c12_dmg)
   );

   hit_channel #(
      .POS_WIDTH(POS_WIDTH), .NUM_ATK(NUM_ATK), .IDX_W(IDX_W), .DMG_WIDTH(DMG_WIDTH),
      .ATK_DAMAGE(ATK_DAMAGE), .CHIP_DAMAGE(CHIP_DAMAGE)
   ) u_p2_to_p1 (
      .clk(clk), .rst_n(rst_n), .frame_tick(frame_tick),
      .atk_action(p2_action), .atk_idx(p2_atk_idx),
      .hitbox_left(p2_hitbox_left), .hitbox_right(p2_hitbox_right),
      .atk_stunned(p2_stunned), .def_action(p1_action),
      .hurt_left(p1_hurtbox_left), .hurt_right(p1_hurtbox_right),
      .hit(c21_hit), .block(c21_block), .dmg(c21_dmg)
   );

   function automatic logic [STUN_WIDTH-1:0] stun_next(input logic [STUN_WIDTH-1:0] cnt,
                                                       input logic hit, input logic blk);
      if (hit)             return HIT_LOAD;
      else if (blk)        return BLK_LOAD;
      else if (cnt != '0)  return cnt - STUN_ONE;
      else                 return cnt;
   endfunction

   // Channel outputs are already gated by frame_tick, so these registers pulse for one clock.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         hit_p1_to_p2   <= 1'b0;
         hit_p2_to_p1   <= 1'b0;
         block_p1_to_p2 <= 1'b0;
         block_p2_to_p1 <= 1'b0;
         p1_dmg         <= '0;
         p2_dmg         <= '0;
         p1_stun_cnt    <= '0;
         p2_stun_cnt    <= '0;
      end else begin
         hit_p1_to_p2   <= c12_hit;
         hit_p2_to_p1   <= c21_hit;
         block_p1_to_p2 <= c12_block;
         block_p2_to_p1 <= c21_block;
         p2_dmg         <= c12_dmg;
         p1_dmg         <= c21_dmg;
         if (frame_tick) begin
            p1_stun_cnt <= stun_next(p1_stun_cnt, c21_hit, c21_block);
            p2_stun_cnt <= stun_next(p2_stun_cnt, c12_hit, c12_block);
         end
      end
   end

endmodule
